// File: rtl/if_stage.sv
// Instruction fetch stage: one-outstanding-request fetch FSM feeding an in-order
// fetch queue, with redirect flush and discard of in-flight words.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  localparam int unsigned PTR_W = (QDEPTH > 2) ? 2 : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       fetch_pc;
  logic [31:0]       inflight_pc;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  fq_entry_t         entries [QDEPTH];

  logic              req_fire;
  logic              push;
  logic              pop;

  assign imem_req_addr = fetch_pc;
  assign id_valid      = (count != '0);

  // Next-state, request handshake and queue push/pop decisions
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    req_fire       = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;

    imem_req_valid = (state == S_RUN) && !redirect_valid && !reset &&
                     (count < CNT_W'(QDEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    push           = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    pop            = id_valid && id_ready && !redirect_valid;

    case (state)
      S_RUN:  if (req_fire) state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid)      state_nxt = S_RUN;
        else if (redirect_valid) state_nxt = S_DROP;
      end
      S_DROP: if (imem_rsp_valid) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_RUN;
      fetch_pc    <= RESET_PC & ~32'h3;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      state <= state_nxt;
      if (req_fire) inflight_pc <= fetch_pc;
      if (redirect_valid) begin
        // Flush wins over any same-cycle push or pop
        fetch_pc <= redirect_pc & ~32'h3;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push)     tail     <= tail + PTR_W'(1);
        if (pop)      head     <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= '{pc: inflight_pc, instr: imem_rsp_data};
  end

  always_comb begin
    id_pc    = '0;
    id_instr = '0;
    if (id_valid) begin
      id_pc    = entries[head].pc;
      id_instr = entries[head].instr;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: memory model plus a queue-based model of the
// expected fetch stream, compared every cycle.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int unsigned QD     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  if_stage #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [63:0] exp_q [$];
  logic [31:0] m_next_pc;
  logic [31:0] m_out_pc;
  bit          m_outstanding;
  bit          m_drop;
  bit          mem_pending;
  int          mem_cnt;
  logic [31:0] mem_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0103;
      1:       return 32'hFFFF_FFF4 | {30'd0, r[1:0]};
      default: return r;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_next_pc     = RST_PC & ~32'h3;
    m_out_pc      = '0;
    m_outstanding = 0;
    m_drop        = 0;
    mem_pending   = 0;
    mem_cnt       = 0;
    mem_addr      = '0;
  endtask

  task automatic check_id_outputs(input string pfx);
    check({pfx, "id_valid"}, {31'd0, id_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check({pfx, "id_pc"},    id_pc,    exp_q[0][63:32]);
      check({pfx, "id_instr"}, id_instr, exp_q[0][31:0]);
    end else begin
      check({pfx, "id_pc_zero"},    id_pc,    32'd0);
      check({pfx, "id_instr_zero"}, id_instr, 32'd0);
    end
  endtask

  // One cycle, entered and left at a falling edge
  task automatic do_cycle(input int p_redir, input int p_rdy, input int p_idr, input int max_lat);
    bit exp_req;
    bit fire;
    bit rsp;
    redirect_valid = ($urandom_range(0, 99) < p_redir);
    redirect_pc    = pick_target();
    imem_req_ready = ($urandom_range(0, 99) < p_rdy);
    id_ready       = ($urandom_range(0, 99) < p_idr);
    imem_rsp_valid = mem_pending && (mem_cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom;
    #1;
    exp_req = !m_outstanding && !redirect_valid && (exp_q.size() < QD);
    check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
    if (exp_req) check("req_addr", imem_req_addr, m_next_pc);
    check_id_outputs("");

    fire = exp_req && imem_req_ready;
    rsp  = imem_rsp_valid;
    if (redirect_valid) begin
      exp_q.delete();
      m_next_pc = redirect_pc & ~32'h3;
      if (rsp) begin
        m_outstanding = 0;
        m_drop        = 0;
      end else if (m_outstanding) begin
        m_drop = 1;
      end
    end else begin
      if (exp_q.size() != 0 && id_ready) void'(exp_q.pop_front());
      if (rsp && m_outstanding) begin
        if (!m_drop) exp_q.push_back({m_out_pc, imem_rsp_data});
        m_outstanding = 0;
        m_drop        = 0;
      end
      if (fire) begin
        m_outstanding = 1;
        m_drop        = 0;
        m_out_pc      = m_next_pc;
        m_next_pc     = m_next_pc + 32'd4;
      end
    end

    if (rsp) mem_pending = 0;
    if (fire) begin
      mem_pending = 1;
      mem_addr    = imem_req_addr;
      mem_cnt     = $urandom_range(1, max_lat) - 1;
    end else if (mem_pending && mem_cnt > 0) begin
      mem_cnt--;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset between edges; outputs must fall before any clock edge
  task automatic do_reset();
    #2;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    id_ready       = 1'b0;
    model_reset();
    #1;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_id_outputs("rst_");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      imem_req_ready = 1'b1;
      #1;
      check("rst_hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check_id_outputs("rst_hold_");
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check("init_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_id_outputs("init_");
    @(negedge clk);
    reset = 1'b0;

    // Streaming, 1-cycle memory: wraps from FFFF_FFF8 through zero
    for (int i = 0; i < 30; i++) do_cycle(0, 100, 100, 1);
    // Consumer stalled until queue fills, then drains
    for (int i = 0; i < 12; i++) do_cycle(0, 100, 0, 2);
    for (int i = 0; i < 12; i++) do_cycle(0, 100, 100, 1);
    // Mixed traffic with redirects and variable latency
    for (int i = 0; i < 400; i++) do_cycle(10, 70, 60, 3);
    do_reset();
    for (int i = 0; i < 20; i++) do_cycle(0, 100, 0, 3);
    do_reset();
    for (int i = 0; i < 400; i++) do_cycle(30, 80, 50, 2);
    // Fill the queue with a word in flight, then reset asynchronously
    for (int i = 0; i < 8; i++) do_cycle(0, 100, 0, 3);
    do_reset();
    for (int i = 0; i < 300; i++) do_cycle(5, 50, 80, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
